// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the cache-to-memory line bus: command encodings,
// responder states and the deterministic power-on line pattern.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    C2_NOP      = 2'd0,
    C2_RESPONSE = 2'd1,
    C2_READ     = 2'd2,
    C2_WRITE    = 2'd3
  } c2_cmd_e;

  localparam int unsigned LINE_BEATS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_COLLECT,
    ST_WAIT,
    ST_RD_SEND,
    ST_WR_ACK
  } state_e;

  // Byte k of line a is a[7:0] ^ {k, 4'b0}.
  function automatic logic [127:0] pattern_line(input logic [7:0] a);
    logic [127:0] l;
    l = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      l[8*k +: 8] = a ^ {k[3:0], 4'b0000};
    end
    return l;
  endfunction

endpackage

// File: rtl/mem_line_responder_beat_shifter.sv
// Beat shifter shared by write collection and read streaming: parallel load,
// beats leave at index 0 and enter at the top.
module mem_beat_shifter #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BEATS*W-1:0] load_line,
  input  logic             shift,
  input  logic [W-1:0]     shift_in,
  output logic [W-1:0]     shift_out,
  output logic [BEATS*W-1:0] shifted_line
);

  logic [BEATS-1:0][W-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (load) begin
      regs <= load_line;
    end else if (shift) begin
      regs <= {shift_in, regs[BEATS-1:1]};
    end
  end

  assign shift_out    = regs[0];
  assign shifted_line = {shift_in, regs[BEATS-1:1]};

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory responder for line READ/WRITE with fixed latency.
// MEM_PATTERN_INIT_EN: reset makes every line read back as the address pattern.
module mem_line_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned BUS_W       = 16,
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned MEM_LATENCY = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_address,
  inout  logic [BUS_W-1:0]  mem_data,
  inout  logic [1:0]        mem_command,
  output logic              protocol_err
);

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned BEATS  = LINE_W / BUS_W;
  localparam int unsigned BW     = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [9:0]    LAT       = 10'(MEM_LATENCY);

  state_e            state;
  logic [9:0]        counter;
  logic [BW-1:0]     beat;
  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  logic              drive_cmd;
  logic              drive_data;

  logic              cmd_rd;
  logic              cmd_wr;
  logic              commit;
  logic              sh_load;
  logic              sh_shift;
  logic [BUS_W-1:0]  sh_out;
  logic [LINE_W-1:0] commit_line;
  logic [LINE_W-1:0] rd_line;
  logic [LINE_W-1:0] storage [2**ADDR_W];

  assign cmd_rd   = (mem_command == C2_READ);
  assign cmd_wr   = (mem_command == C2_WRITE);
  assign sh_load  = (state == ST_IDLE) && cmd_rd;
  assign sh_shift = ((state == ST_IDLE) && cmd_wr) || (state == ST_WR_COLLECT) ||
                    (state == ST_RD_SEND);
  assign commit   = (state == ST_WR_COLLECT) && (beat == LAST_BEAT);

  mem_beat_shifter #(
    .BEATS (BEATS),
    .W     (BUS_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load         (sh_load),
    .load_line    (rd_line),
    .shift        (sh_shift),
    .shift_in     (mem_data),
    .shift_out    (sh_out),
    .shifted_line (commit_line)
  );

  assign mem_command = drive_cmd  ? C2_RESPONSE : 'z;
  assign mem_data    = drive_data ? sh_out      : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      counter      <= '0;
      beat         <= '0;
      is_write     <= 1'b0;
      addr_q       <= '0;
      drive_cmd    <= 1'b0;
      drive_data   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if ((state != ST_IDLE) && !drive_cmd && (cmd_rd || cmd_wr)) begin
        protocol_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_rd || cmd_wr) begin
            addr_q   <= mem_address;
            is_write <= cmd_wr;
            counter  <= 10'd1;
            beat     <= BW'(1);
            state    <= cmd_wr ? ST_WR_COLLECT : ST_WAIT;
          end
        end
        ST_WR_COLLECT: begin
          counter <= counter + 10'd1;
          if (beat == LAST_BEAT) begin
            state <= ST_WAIT;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        ST_WAIT: begin
          if (counter == LAT) begin
            drive_cmd  <= 1'b1;
            drive_data <= !is_write;
            beat       <= '0;
            state      <= is_write ? ST_WR_ACK : ST_RD_SEND;
          end else begin
            counter <= counter + 10'd1;
          end
        end
        ST_RD_SEND: begin
          if (beat == LAST_BEAT) begin
            drive_cmd  <= 1'b0;
            drive_data <= 1'b0;
            counter    <= '0;
            state      <= ST_IDLE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        ST_WR_ACK: begin
          drive_cmd <= 1'b0;
          counter   <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      storage[addr_q] <= commit_line;
    end
  end

`ifdef MEM_PATTERN_INIT_EN
  // Reset clears a per-line written flag instead of rewriting every line;
  // unwritten lines read as the pattern, which is observably identical.
  logic [2**ADDR_W-1:0] written;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written <= '0;
    end else if (commit) begin
      written[addr_q] <= 1'b1;
    end
  end

  assign rd_line = written[mem_address] ? storage[mem_address]
                                        : LINE_W'(pattern_line(8'(mem_address)));
`else
  assign rd_line = storage[mem_address];
`endif

endmodule
